// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage.
// Contents: ISA width, PC increment, default HALT opcode and NOP word, the fetch FSM state
// encoding, and a saturating 32-bit add used by the optional performance counters.
package fetch_pkg;

  localparam int unsigned IsaW     = 16;
  localparam logic [15:0] PcInc    = 16'd2;
  localparam logic [4:0]  HaltOpc  = 5'b00000;
  localparam logic [15:0] NopInstr = 16'h0800;

  // StIdle: nothing outstanding; StWait: read outstanding, result kept;
  // StDrain: read outstanding, result discarded; StHalt: terminal until reset.
  typedef enum logic [1:0] {StIdle, StWait, StDrain, StHalt} fetch_state_e;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Instruction buffer: BUF_DEPTH-entry FIFO of 32-bit {instr, pc_plus2} words.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   push, wdata   write an entry
//   pop           remove the head entry
//   flush         empty the buffer; wins over push and pop
//   count, head   occupancy and head entry
//   empty         count == 0
module fetch_buf #(
  parameter int unsigned BUF_DEPTH = 2,
  localparam int unsigned PtrW = $clog2(BUF_DEPTH),
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [31:0]     wdata,
  output logic [CntW-1:0] count,
  output logic [31:0]     head,
  output logic            empty
);

  logic [31:0]     mem_q [BUF_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Pointers wrap naturally because BUF_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding decode.
// Owns the PC, issues one-outstanding reads to instruction memory, buffers returned words with
// their PC+2, and hands them to decode under a valid/stall handshake. Handles redirects
// (squashing an in-flight read) and stops at a HALT opcode.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   fetch_en, stall           decode's issue enable and back-pressure
//   redirect, redirect_pc     taken branch/jump and its target
//   imem_req/addr/rdata/done  instruction memory read interface
//   instr_out, pc_plus2_out   head entry (NOP/0 when empty)
//   instr_valid               head entry present
//   halted, err               sticky HALT-taken and misaligned-redirect flags
// Optional: define FETCH_PERF_CNT_EN to add perf_fetched, perf_squashed, perf_stall_cyc.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [15:0] NOP_INSTR = NopInstr,
  parameter logic [4:0]  HALT_OPC  = HaltOpc
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic            stall,
  input  logic            redirect,
  input  logic [IsaW-1:0] redirect_pc,
  output logic            imem_req,
  output logic [IsaW-1:0] imem_addr,
  input  logic [IsaW-1:0] imem_rdata,
  input  logic            imem_done,
  output logic [IsaW-1:0] instr_out,
  output logic [IsaW-1:0] pc_plus2_out,
  output logic            instr_valid,
  output logic            halted,
  output logic            err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_squashed,
  output logic [31:0]     perf_stall_cyc
`endif
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [IsaW-1:0] fetch_pc_q, fetch_pc_d;
  logic [IsaW-1:0] addr_q, addr_d;
  logic            halt_pending_q, halt_pending_d;
  logic            err_q, err_d;

  logic            outstanding, can_issue, keep, push, pop, flush, empty;
  logic [CntW-1:0] count;
  logic [31:0]     head, push_data;

  fetch_buf #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata(push_data),
    .count(count),
    .head (head),
    .empty(empty)
  );

  assign outstanding = (state_q == StWait) || (state_q == StDrain);
  assign can_issue   = fetch_en && !halt_pending_q &&
                       ((32'(count) + 32'(outstanding)) < BUF_DEPTH);
  assign imem_req    = ((state_q == StIdle) && can_issue) || outstanding;
  // While outstanding the address comes from a register so it cannot move under the memory.
  assign imem_addr   = (state_q == StIdle) ? fetch_pc_q : addr_q;

  // A redirect flushes the buffer this edge, so its head is not offered to decode.
  assign instr_valid  = !empty && (state_q != StHalt) && !redirect;
  assign pop          = instr_valid && !stall;
  assign instr_out    = empty ? NOP_INSTR : head[31:16];
  assign pc_plus2_out = empty ? '0 : head[15:0];
  assign halted       = (state_q == StHalt);
  assign err          = err_q;
  assign push_data    = {imem_rdata, fetch_pc_q + PcInc};

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    addr_d         = (state_q == StIdle) ? fetch_pc_q : addr_q;
    halt_pending_d = halt_pending_q;
    err_d          = err_q;
    keep           = 1'b0;
    push           = 1'b0;
    flush          = 1'b0;
    if (state_q != StHalt) begin
      if (redirect) begin
        flush          = 1'b1;
        halt_pending_d = 1'b0;
        fetch_pc_d     = {redirect_pc[IsaW-1:1], 1'b0};
        if (redirect_pc[0]) err_d = 1'b1;
        // A request already presented must be seen through, but its data is dropped.
        state_d = (imem_req && !imem_done) ? StDrain : StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (can_issue) begin
              if (imem_done) keep = 1'b1;
              else           state_d = StWait;
            end
          end
          StWait: begin
            if (imem_done) begin
              keep    = 1'b1;
              state_d = StIdle;
            end
          end
          StDrain: begin
            if (imem_done) state_d = StIdle;
          end
          default: ;
        endcase
        if (keep) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + PcInc;
          if (imem_rdata[15:11] == HALT_OPC) halt_pending_d = 1'b1;
        end
        if (pop && (head[31:27] == HALT_OPC)) state_d = StHalt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      fetch_pc_q     <= RESET_PC;
      addr_q         <= RESET_PC;
      halt_pending_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      addr_q         <= addr_d;
      halt_pending_q <= halt_pending_d;
      err_q          <= err_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_squashed_q, perf_stall_cyc_q;
  logic        discard;
  logic [31:0] squash_inc;

  // Reads whose data is thrown away: completions in DRAIN or alongside a redirect.
  assign discard    = imem_req && imem_done && ((state_q == StDrain) || redirect) &&
                      (state_q != StHalt);
  assign squash_inc = 32'(discard) + (flush ? 32'(count) : 32'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q   <= '0;
      perf_squashed_q  <= '0;
      perf_stall_cyc_q <= '0;
    end else if (state_q != StHalt) begin
      perf_fetched_q   <= sat_add(perf_fetched_q, 32'(push));
      perf_squashed_q  <= sat_add(perf_squashed_q, squash_inc);
      perf_stall_cyc_q <= sat_add(perf_stall_cyc_q, 32'(instr_valid && stall));
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_squashed  = perf_squashed_q;
  assign perf_stall_cyc = perf_stall_cyc_q;
`endif

endmodule
